output_port: RTL and testbench
==============================

# output_port

Bus-side output port for the 8-bit CPU: the consumer end of the W-bus load protocol. When the controller asserts `lo`, the byte on `data_in` is captured into a small FIFO. The FIFO drains to an external sink (display driver, UART, testbench) over a valid/ready handshake. A `full` flag goes back to the controller so it can stall OUT instructions instead of losing data.

## Interface
- `WIDTH`, 8, data width of bus and FIFO entries
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `clk`  input  1  single system clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state immediately
- `data_in`  input  WIDTH  W-bus byte, sampled only when `lo` is high
- `lo`  input  1  load strobe from controller, one push per high cycle
- `full`  output  1  high when count == DEPTH
- `count`  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- `dout`  output  WIDTH  head-of-FIFO byte; 0 when empty
- `dout_valid`  output  1  high when count != 0
- `dout_ready`  input  1  sink accepts `dout` on cycles with `dout_valid` high
- `ovf`  output  1  sticky overflow flag (see Configuration)

## Operation
- Storage: DEPTH x WIDTH register array, write pointer `wp`, read pointer `rp`, counter `count`; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Pop: occurs when `dout_valid && dout_ready`; `rp` increments.
- Push: occurs when `lo && (!full || pop)`. `mem[wp] <= data_in`, then `wp` increments.
- Simultaneous push and pop:
  - `count` is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same edge.
  - When empty, no pop happens because `dout_valid` is low, so the cycle is a push only.
- Rejected push: `lo` while full with no pop. The byte is dropped and storage is unchanged.
- `dout` and `dout_valid` are registered, derived from next-state head and count. No combinational path from `lo` or `data_in` to outputs.
- `dout_ready` with `dout_valid` low: ignored.
- `dout` must stay stable while `dout_valid && !dout_ready`.
- Reset (any time, including mid-drain):
  - `wp`, `rp`, `count` go to 0.
  - `dout_valid` goes to 0, `dout` to 0, `full` to 0, `ovf` to 0.
  - Array contents are not cleared.
  - Outputs are already at reset values during the first cycle after `reset` deasserts.

## Timing
- Push latency: byte loaded at edge N into an empty FIFO gives `dout_valid`=1 and `dout`=byte after edge N, so it is visible in cycle N+1.
- Pop: the byte accepted at edge M is replaced after edge M by the next entry, or by 0 with `dout_valid`=0 if it was the last.
- Throughput: one push and one pop per cycle sustained.
- `full` and `count` update on the same edge as the push or pop that changes them.
- `full` is registered. The controller sees `full` in the cycle after the push that filled the FIFO.

## Configuration
- `OUTPUT_PORT_OVF_EN` defined:
  - `ovf` sets on the edge of any rejected push.
  - It stays set until `reset`.
  - A rejected push never alters FIFO contents or count.
- Not defined:
  - `ovf` is tied to 0 and no flag flop is built.
  - Rejected pushes are still silently dropped.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with 2 entries stored → `count`=0, `dout_valid`=0, `dout`=0, `full`=0, `ovf`=0 before the next edge.
- Single byte: `lo` one cycle with `data_in`=8'hA5, `dout_ready`=0 → next cycle `dout`=8'hA5, `dout_valid`=1, `count`=1. Raise `dout_ready` → after the next edge, `dout_valid`=0 and `dout`=0.
- Fill and order:
  - Push 8'h01..8'h04 with `dout_ready`=0 → `full`=1, `count`=4.
  - Drain with `dout_ready`=1 → outputs 01, 02, 03, 04 on consecutive cycles, then empty.
- Overflow: with the FIFO full, push 8'hFF with no pop → `count` stays 4 and the drain yields 01..04 only. `ovf`=1 if `OUTPUT_PORT_OVF_EN` is defined, else 0.
- Full push+pop: with the FIFO full, `lo`=1 (8'h55) and `dout_ready`=1 in the same cycle → `count` stays 4, `ovf` stays 0, and 8'h55 emerges last.
- Wrap: stream 20 bytes with `lo` and `dout_ready` both high every cycle → output is identical in order to the input, one cycle behind, and `count` stays 1 after the first push.

Source files
------------

// File: rtl/output_port.sv
// output_port: W-bus output port FIFO with valid/ready drain.
// Captures data_in on each lo strobe into a DEPTH-entry FIFO, drains over a
// registered valid/ready interface, and reports full/count to the controller.
// Optional macro OUTPUT_PORT_OVF_EN builds a sticky overflow flag on rejected
// pushes; without it ovf is tied low.
module output_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     lo,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             full_q, full_d;
    logic             pop, push;

    // Next-state pointers, occupancy and registered head-of-FIFO view
    always_comb begin
        pop     = dout_valid_q && dout_ready;
        push    = lo && (!full_q || pop);
        wp_d    = push ? wp_q + PW'(1) : wp_q;
        rp_d    = pop  ? rp_q + PW'(1) : rp_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        dout_valid_d = (count_d != '0);
        full_d       = (count_d == DEPTH_C);
        // The new head may be the slot being written this same edge
        // (push into empty, or push+pop with one entry), so bypass data_in.
        if (!dout_valid_d) begin
            dout_d = '0;
        end else if (push && (wp_q == rp_d)) begin
            dout_d = data_in;
        end else begin
            dout_d = mem_q[rp_d];
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            full_q       <= full_d;
        end
    end

    // Storage array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= data_in;
        end
    end

`ifdef OUTPUT_PORT_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: any lo that could not be accepted
    always_comb begin
        ovf_d = ovf_q | (lo && !push);
    end

    // Overflow flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign full       = full_q;
    assign count      = count_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_output_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             lo = 1'b0;
    logic             full;
    logic [2:0]       count;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic             ovf_m = 1'b0;

    output_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .lo         (lo),
        .full       (full),
        .count      (count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] m_dout();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    function automatic logic [2:0] m_count();
        return 3'(q.size());
    endfunction

    // One clock: drive at negedge, update model at posedge, return 1 after it
    task automatic step(input logic l, input logic [WIDTH-1:0] d, input logic r);
        bit pop_m, push_m;
        @(negedge clk);
        lo = l; data_in = d; dout_ready = r;
        @(posedge clk);
        pop_m  = (q.size() != 0) && r;
        push_m = l && ((q.size() < DEPTH) || pop_m);
`ifdef OUTPUT_PORT_OVF_EN
        if (l && !push_m) ovf_m = 1'b1;
`endif
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        lo = 1'b0; dout_ready = 1'b0; reset = 1'b1;
        q.delete(); ovf_m = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL reset_pre_count got %0d want 2", count); end
        #2;
        reset = 1'b1; lo = 1'b0;
        q.delete(); ovf_m = 1'b0;
        #1;
        checks++;
        if ({count, dout_valid, dout, full, ovf} !== {3'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got count=%0d valid=%b dout=%h full=%b ovf=%b want all 0",
                     count, dout_valid, dout, full, ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({count, dout_valid, dout, full} !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_after got count=%0d valid=%b dout=%h full=%b want all 0",
                     count, dout_valid, dout, full);
        end
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        checks++;
        if ({dout, dout_valid, count} !== {8'hA5, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single_push got dout=%h valid=%b count=%0d want a5 1 1", dout, dout_valid, count);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", dout); end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if ({dout, dout_valid, count} !== {8'h00, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_pop got dout=%h valid=%b count=%0d want 00 0 0", dout, dout_valid, count);
        end
    endtask

    task automatic fill_1234();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    endtask

    task automatic drain_check(input string name, input logic [WIDTH-1:0] exp[$]);
        foreach (exp[i]) begin
            checks++;
            if ({dout_valid, dout} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL %s_drain%0d got valid=%b dout=%h want 1 %h", name, i, dout_valid, dout, exp[i]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if ({dout_valid, dout, count} !== {1'b0, 8'h00, 3'd0}) begin
            errors++;
            $display("FAIL %s_empty got valid=%b dout=%h count=%0d want 0 00 0", name, dout_valid, dout, count);
        end
    endtask

    task automatic test_fill_order();
        do_reset();
        fill_1234();
        checks++;
        if ({full, count} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL fill_full got full=%b count=%0d want 1 4", full, count);
        end
        drain_check("fill", '{8'h01, 8'h02, 8'h03, 8'h04});
    endtask

    task automatic test_overflow();
        logic exp_ovf;
`ifdef OUTPUT_PORT_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        do_reset();
        fill_1234();
        step(1'b1, 8'hFF, 1'b0);
        checks++;
        if ({count, full, ovf} !== {3'd4, 1'b1, exp_ovf}) begin
            errors++;
            $display("FAIL ovf_flag got count=%0d full=%b ovf=%b want 4 1 %b", count, full, ovf, exp_ovf);
        end
        drain_check("ovf", '{8'h01, 8'h02, 8'h03, 8'h04});
        checks++;
        if (ovf !== exp_ovf) begin errors++; $display("FAIL ovf_sticky got %b want %b", ovf, exp_ovf); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        fill_1234();
        step(1'b1, 8'h55, 1'b1);
        checks++;
        if ({count, full, ovf, dout} !== {3'd4, 1'b1, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL fullpp got count=%0d full=%b ovf=%b dout=%h want 4 1 0 02", count, full, ovf, dout);
        end
        drain_check("fullpp", '{8'h02, 8'h03, 8'h04, 8'h55});
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] b [20];
        do_reset();
        foreach (b[i]) b[i] = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, b[i], 1'b1);
            checks++;
            if ({dout_valid, dout, count} !== {1'b1, b[i], 3'd1}) begin
                errors++;
                $display("FAIL wrap%0d got valid=%b dout=%h count=%0d want 1 %h 1", i, dout_valid, dout, count, b[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45));
            checks++;
            if ({count, full, dout_valid, dout, ovf} !==
                {m_count(), (q.size() == DEPTH), (q.size() != 0), m_dout(), ovf_m}) begin
                errors++;
                $display("FAIL rand%0d got count=%0d full=%b valid=%b dout=%h ovf=%b want %0d %b %b %h %b",
                         i, count, full, dout_valid, dout, ovf,
                         m_count(), (q.size() == DEPTH), (q.size() != 0), m_dout(), ovf_m);
            end
        end
    endtask

    initial begin
        #1;
        checks++;
        if ({count, dout_valid, dout, full, ovf} !== {3'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL power_on_reset got count=%0d valid=%b dout=%h full=%b ovf=%b",
                     count, dout_valid, dout, full, ovf);
        end
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
